// File: rtl/muldiv_ctrl.sv
// Sequencing controller for the shared HI/LO multiply/divide resources in EX:
// issues one op to the multiplier or divider, stalls EX, and holds the result.
module muldiv_ctrl #(
  parameter int MULT_LAT = 9,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic        op_is_div,
  input  logic        op_sign,
  input  logic        flush,
  input  logic        stall_next,
  output logic        mult_ce,
  output logic        mult_sign,
  output logic        mult_sclr,
  input  logic [63:0] mult_p,
  output logic        div_opn_valid,
  output logic        div_sign,
  output logic        div_rst,
  input  logic        div_res_valid,
  output logic        div_res_ready,
  input  logic [63:0] div_result,
  output logic [63:0] result,
  output logic        result_valid,
  output logic        stall_e,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MULT_LAT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] mult_cnt_q, mult_cnt_d;
  logic [63:0]      result_q, result_d;
  logic             sign_q, sign_d;
  logic             abort;

  // Reset and flush both clear the arithmetic units and cancel the op.
  assign abort = rst | flush;

  // NOTE: sequential state uses non-blocking assignments only, and the reset
  // here is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mult_cnt_q <= '0;
      result_q   <= '0;
      sign_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mult_cnt_q <= mult_cnt_d;
      result_q   <= result_d;
      sign_q     <= sign_d;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is
  // inferred on paths where a case arm does not assign it.
  always_comb begin
    state_d       = state_q;
    mult_cnt_d    = mult_cnt_q;
    result_d      = result_q;
    sign_d        = sign_q;
    mult_ce       = 1'b0;
    div_opn_valid = 1'b0;
    div_res_ready = 1'b0;
    stall_e       = 1'b0;
    result_valid  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          stall_e    = 1'b1;
          sign_d     = op_sign;
          mult_cnt_d = '0;
          state_d    = op_is_div ? S_DIV : S_MULT;
        end
      end
      S_MULT: begin
        stall_e = 1'b1;
        if (mult_cnt_q < LAT) begin
          mult_ce    = 1'b1;
          mult_cnt_d = mult_cnt_q + CNT_W'(1);
        end else begin
          result_d = mult_p;
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        stall_e       = 1'b1;
        div_opn_valid = 1'b1;
        if (div_res_valid) begin
          div_res_ready = 1'b1;
          result_d      = div_result;
          state_d       = S_DONE;
        end
      end
      S_DONE: begin
        result_valid = 1'b1;
        if (!stall_next) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort outranks every completion event: nothing is captured or issued.
    if (abort) begin
      state_d       = S_IDLE;
      mult_cnt_d    = '0;
      result_d      = result_q;
      sign_d        = sign_q;
      mult_ce       = 1'b0;
      div_opn_valid = 1'b0;
      div_res_ready = 1'b0;
      stall_e       = 1'b0;
      result_valid  = 1'b0;
    end
  end

  assign mult_sclr = abort;
  assign div_rst   = abort;
  assign mult_sign = sign_q;
  assign div_sign  = sign_q;
  assign result    = result_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl with a CE-gated pipeline model
// of the multiplier and a bench-driven divider handshake.
module tb_muldiv_ctrl;

  localparam int MULT_LAT = 9;
  localparam int CNT_W    = 4;

  logic        clk = 1'b0;
  logic        rst, op_valid, op_is_div, op_sign, flush, stall_next;
  logic        mult_ce, mult_sign, mult_sclr;
  logic [63:0] mult_p;
  logic        div_opn_valid, div_sign, div_rst, div_res_valid, div_res_ready;
  logic [63:0] div_result, result;
  logic        result_valid, stall_e, busy;

  logic [63:0] prod_in;
  logic [63:0] pipe [MULT_LAT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MULT_LAT(MULT_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_is_div(op_is_div),
    .op_sign(op_sign), .flush(flush), .stall_next(stall_next),
    .mult_ce(mult_ce), .mult_sign(mult_sign), .mult_sclr(mult_sclr),
    .mult_p(mult_p), .div_opn_valid(div_opn_valid), .div_sign(div_sign),
    .div_rst(div_rst), .div_res_valid(div_res_valid),
    .div_res_ready(div_res_ready), .div_result(div_result),
    .result(result), .result_valid(result_valid), .stall_e(stall_e),
    .busy(busy)
  );

  // Multiplier model: the product appears after exactly MULT_LAT enabled cycles.
  always @(posedge clk) begin
    if (mult_sclr) begin
      for (int i = 0; i < MULT_LAT; i++) pipe[i] <= '0;
    end else if (mult_ce) begin
      pipe[0] <= prod_in;
      for (int i = 1; i < MULT_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mult_p = pipe[MULT_LAT-1];

  // The op must stay in EX while the unit is working unless it is flushed.
  property p_op_held;
    @(posedge clk) disable iff (rst) (busy && !result_valid && !flush) |-> op_valid;
  endproperty
  a_op_held: assert property (p_op_held) else $error("op_valid dropped mid-operation");

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issues a multiply and waits for result_valid; leaves the op in DONE when hold is set.
  task automatic run_mult(input string tag, input logic [63:0] prod, input logic sgn,
                          input bit hold);
    int n_stall = 0;
    int n_ce    = 0;
    op_valid  = 1'b1;
    op_is_div = 1'b0;
    op_sign   = sgn;
    prod_in   = prod;
    #1;
    check({tag, "_arrive_stall"}, 64'(stall_e), 64'd1);
    for (int n = 0; n < 40; n++) begin
      tick();
      if (result_valid) break;
      n_stall += int'(stall_e);
      n_ce    += int'(mult_ce);
    end
    check({tag, "_done"},       64'(result_valid), 64'd1);
    check({tag, "_stall_cnt"},  64'(n_stall), 64'd10);
    check({tag, "_ce_cnt"},     64'(n_ce), 64'd9);
    check({tag, "_result"},     result, prod);
    check({tag, "_sign"},       64'(mult_sign), 64'(sgn));
    check({tag, "_done_stall"}, 64'(stall_e), 64'd0);
    check({tag, "_done_ce"},    64'(mult_ce), 64'd0);
    if (!hold) begin
      op_valid = 1'b0;
      tick();
      check({tag, "_idle"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int n_opn;
    int n_rdy;
    rst = 1'b1; op_valid = 1'b0; op_is_div = 1'b0; op_sign = 1'b0;
    flush = 1'b0; stall_next = 1'b0; div_res_valid = 1'b0;
    div_result = '0; prod_in = '0;

    tick(); tick();
    check("rst_div_rst",   64'(div_rst), 64'd1);
    check("rst_mult_sclr", 64'(mult_sclr), 64'd1);
    rst = 1'b0;
    tick();
    check("rst_busy",   64'(busy), 64'd0);
    check("rst_rv",     64'(result_valid), 64'd0);
    check("rst_stall",  64'(stall_e), 64'd0);
    check("rst_result", result, 64'd0);

    // 1: unsigned multiply
    run_mult("mul_u", 64'h0000_0001_FFFF_FFFE, 1'b0, 1'b0);

    // 2: signed divide, result 34 cycles after the operand is first offered
    op_valid = 1'b1; op_is_div = 1'b1; op_sign = 1'b1;
    tick();
    check("div_opn",       64'(div_opn_valid), 64'd1);
    check("div_sign",      64'(div_sign), 64'd1);
    check("div_stall",     64'(stall_e), 64'd1);
    n_opn = 0; n_rdy = 0;
    repeat (33) begin
      tick();
      n_opn += int'(div_opn_valid);
      n_rdy += int'(div_res_ready);
    end
    check("div_wait_opn", 64'(n_opn), 64'd33);
    check("div_wait_rdy", 64'(n_rdy), 64'd0);
    tick();
    div_res_valid = 1'b1; div_result = 64'h0000_0001_0000_0003;
    #1;
    check("div_rdy_pulse",  64'(div_res_ready), 64'd1);
    check("div_stall_last", 64'(stall_e), 64'd1);
    tick();
    div_res_valid = 1'b0;
    #1;
    check("div_rv",         64'(result_valid), 64'd1);
    check("div_result",     result, 64'h0000_0001_0000_0003);
    check("div_stall_drop", 64'(stall_e), 64'd0);
    check("div_rdy_low",    64'(div_res_ready), 64'd0);
    check("div_opn_low",    64'(div_opn_valid), 64'd0);
    check("div_sign_held",  64'(div_sign), 64'd1);
    op_valid = 1'b0;
    tick();
    check("div_idle", 64'(busy), 64'd0);

    // 3: flush on the fifth divide cycle, then a stale res_valid
    op_valid = 1'b1; op_is_div = 1'b1; op_sign = 1'b0;
    tick();
    repeat (4) tick();
    flush = 1'b1;
    #1;
    check("fl_div_rst", 64'(div_rst), 64'd1);
    check("fl_stall",   64'(stall_e), 64'd0);
    check("fl_opn",     64'(div_opn_valid), 64'd0);
    tick();
    flush = 1'b0; op_valid = 1'b0;
    #1;
    check("fl_idle", 64'(busy), 64'd0);
    check("fl_rv",   64'(result_valid), 64'd0);
    div_res_valid = 1'b1; div_result = 64'hDEAD_BEEF_CAFE_F00D;
    #1;
    check("fl_late_rdy", 64'(div_res_ready), 64'd0);
    tick();
    div_res_valid = 1'b0;
    check("fl_late_rv",     64'(result_valid), 64'd0);
    check("fl_late_busy",   64'(busy), 64'd0);
    check("fl_late_result", result, 64'h0000_0001_0000_0003);

    // 4: flush in the same cycle the product becomes valid
    op_valid = 1'b1; op_is_div = 1'b0; op_sign = 1'b1; prod_in = 64'hAAAA_5555_1234_5678;
    tick();
    repeat (9) tick();
    check("fm_last_ce",    64'(mult_ce), 64'd0);
    check("fm_last_stall", 64'(stall_e), 64'd1);
    flush = 1'b1;
    #1;
    check("fm_sclr",  64'(mult_sclr), 64'd1);
    check("fm_stall", 64'(stall_e), 64'd0);
    tick();
    flush = 1'b0; op_valid = 1'b0;
    #1;
    check("fm_rv",     64'(result_valid), 64'd0);
    check("fm_busy",   64'(busy), 64'd0);
    check("fm_result", result, 64'h0000_0001_0000_0003);

    // 5: downstream stall holds DONE, then an immediate second multiply
    run_mult("hold_a", 64'h0000_0000_0000_0042, 1'b0, 1'b1);
    stall_next = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_result", result, 64'h0000_0000_0000_0042);
      check("hold_rv",     64'(result_valid), 64'd1);
      check("hold_ce",     64'(mult_ce), 64'd0);
      check("hold_opn",    64'(div_opn_valid), 64'd0);
    end
    stall_next = 1'b0; op_valid = 1'b0;
    tick();
    check("hold_release", 64'(busy), 64'd0);
    run_mult("hold_b", 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b0);

    // 6: reset in the middle of a multiply, then a full fresh multiply
    op_valid = 1'b1; op_is_div = 1'b0; op_sign = 1'b1; prod_in = 64'h1111_2222_3333_4444;
    tick();
    repeat (4) tick();
    check("rm_ce_mid", 64'(mult_ce), 64'd1);
    rst = 1'b1; op_valid = 1'b0;
    #1;
    check("rm_sclr",   64'(mult_sclr), 64'd1);
    check("rm_divrst", 64'(div_rst), 64'd1);
    tick();
    rst = 1'b0;
    #1;
    check("rm_busy",   64'(busy), 64'd0);
    check("rm_rv",     64'(result_valid), 64'd0);
    check("rm_stall",  64'(stall_e), 64'd0);
    check("rm_result", result, 64'd0);
    check("rm_ce",     64'(mult_ce), 64'd0);
    check("rm_opn",    64'(div_opn_valid), 64'd0);
    check("rm_sign",   64'({mult_sign, div_sign}), 64'd0);
    run_mult("rm_fresh", 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
